alu32_reg: RTL and testbench
============================

Name: alu32_reg

Overview:
- 32-bit integer ALU with four operations: add, XOR, subtract and signed set-less-than.
- Produces carry, overflow, negative and zero status flags.
- The datapath is combinational, built structurally from ripple-carry full adders and bitwise logic.
- Result and flags are captured in an output register, for use as the execute-stage ALU of a simple single-issue datapath.

Parameters:
- None. The width is fixed at 32 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- BussA  input  32  operand A
- BussB  input  32  operand B
- ALUControl  input  2  operation select: 00 add, 01 xor, 10 sub, 11 slt
- Output  output  32  registered result
- CarryOut  output  1  registered carry out of bit 31 of the adder/subtractor
- overflow  output  1  registered signed overflow of the adder/subtractor
- negative  output  1  registered Output[31]
- zero  output  1  registered; 1 when the registered Output equals 0

Behaviour:
- Reset: rst_n low asynchronously forces Output=0, CarryOut=0, overflow=0, negative=0, zero=1. All registers hold these values while rst_n is low.
- Clock: on each rising clk with rst_n high, all five outputs load their combinational next values. Latency is exactly 1 cycle. There is no enable and no handshake; a new operation can be issued every cycle.
- Subtract mode: sub = ALUControl[1] OR ALUControl[0].
  - Adder operand: B' = sub ? ~BussB : BussB.
  - Carry into bit 0 = sub.
  - The adder is a 32-stage ripple of full adders, with c[i] the carry out of bit i.
  - AddSub = BussA + B' + sub, modulo 2^32.
- Flags and derived values from the adder:
  - nextCarryOut = c[31]. For subtract this is 1 when there is no borrow (unsigned A >= B).
  - nextOverflow = c[31] XOR c[30].
  - slt = nextOverflow XOR AddSub[31]. This is the signed A < B comparison.
- Result mux, selected by ALUControl:
  - 00: AddSub (A+B)
  - 01: BussA XOR BussB (bitwise)
  - 10: AddSub (A-B)
  - 11: {31'b0, slt}
- Flags in XOR and SLT modes:
  - CarryOut and overflow always reflect the adder, which performs A-B for ALUControl 01 and 11.
  - Consumers ignore CarryOut and overflow for XOR and SLT; the bench checks them there only as A-B values.
- Result-derived flags: negative = result[31]; zero = NOR of all 32 result bits. Both are computed from the selected result before the register.
- Wrap-around: all arithmetic is modulo 2^32 and overflow never saturates the result.
- Boundary cases:
  - A=B in slt mode gives 0.
  - 0x80000000 slt 0x00000001 gives 1 (signed comparison).
  - Subtracting 0 gives CarryOut=1.
- Changes on the inputs between clock edges have no effect on the outputs.
- Asserting rst_n mid-stream discards the in-flight result; the first valid result appears one edge after rst_n deasserts.

Test Plan:
- Reset check: hold rst_n=0 with random inputs -> Output=0, zero=1, all other flags 0. Release rst_n, apply ctl=00, A=0x0DEF, B=0x0ABC -> after 1 edge: Output=0x000018AB, CarryOut=0, overflow=0, negative=0, zero=0.
- Add overflow: ctl=00, A=0x7FFFFFFF, B=1 -> Output=0x80000000, overflow=1, negative=1, CarryOut=0. Then A=0, B=0 -> Output=0, zero=1.
- Subtract cases, all with ctl=10:
  - A=0x0DEF, B=0x0ABC -> Output=0x00000333, CarryOut=1.
  - A=0x1234, B=0x0105 -> Output=0x0000112F.
  - A=0x80000000, B=1 -> Output=0x7FFFFFFF, overflow=1, negative=0.
  - A=B=0x7FFFFFFF -> Output=0, zero=1, CarryOut=1.
- XOR cases, all with ctl=01:
  - A=0, B=1 -> Output=0x00000001.
  - A=0x0DEF, B=0x0ABC -> Output=0x00000753.
  - A=0x1234, B=0x0105 -> Output=0x00001331.
- SLT cases, all with ctl=11:
  - (0,1) -> Output=1.
  - (1,0) -> Output=0, zero=1.
  - (0,0) -> Output=0, zero=1.
  - (0x80000000, 1) -> Output=1.
  - (0x7FFFFFFF, 0xFFFFFFFF) -> Output=0.
- Pipelining and async reset: change the operands every cycle and check that each output equals the function of the inputs sampled at the prior edge. Pulse rst_n low between edges -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu32_reg.sv
// Execute-stage ALU: add / xor / sub / signed slt over a structural ripple-carry
// adder, with result and status flags captured in a single output register.

module alu32_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (p & ci);
endmodule

module alu32_ripple #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);
  // Each stage keeps its own scalar carry so the chain is a plain net-to-net ripple.
  for (genvar i = 0; i < W; i++) begin : g_fa
    logic cin;
    logic co;
    if (i == 0) begin : g_lsb
      assign cin = ci;
    end else begin : g_mid
      assign cin = g_fa[i-1].co;
    end
    alu32_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (cin),
      .s  (s[i]),
      .co (co)
    );
    assign c[i] = co;
  end
endmodule

module alu32_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] BussA,
  input  logic [31:0] BussB,
  input  logic [1:0]  ALUControl,
  output logic [31:0] Output,
  output logic        CarryOut,
  output logic        overflow,
  output logic        negative,
  output logic        zero
);
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         n;
    logic         z;
  } alu_rsp_t;

  localparam alu_rsp_t RST_RSP = '{res: '0, c: 1'b0, v: 1'b0, n: 1'b0, z: 1'b1};

  logic         sub;
  logic [W-1:0] bop;
  logic [W-1:0] addsub;
  logic [W-1:0] cy;
  logic [W-1:0] xres;
  logic         slt;
  alu_rsp_t     nxt;
  alu_rsp_t     q;

  // Every mode except plain add drives the adder as A - B, so flags stay meaningful.
  assign sub = ALUControl[1] | ALUControl[0];
  assign bop = sub ? ~BussB : BussB;

  alu32_ripple #(.W(W)) u_add (
    .a  (BussA),
    .b  (bop),
    .ci (sub),
    .s  (addsub),
    .c  (cy)
  );

  assign xres = BussA ^ BussB;

  always_comb begin
    nxt   = RST_RSP;
    nxt.c = cy[W-1];
    nxt.v = cy[W-1] ^ cy[W-2];
    slt   = nxt.v ^ addsub[W-1];
    unique case (ALUControl)
      2'b00:   nxt.res = addsub;
      2'b01:   nxt.res = xres;
      2'b10:   nxt.res = addsub;
      default: nxt.res = {{(W-1){1'b0}}, slt};
    endcase
    nxt.n = nxt.res[W-1];
    nxt.z = ~|nxt.res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_RSP;
    else        q <= nxt;
  end

  assign Output   = q.res;
  assign CarryOut = q.c;
  assign overflow = q.v;
  assign negative = q.n;
  assign zero     = q.z;
endmodule

// File: tb/tb_alu32_reg.sv
// Randomized and directed bench for alu32_reg against an arithmetic reference model.

module tb_alu32_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] BussA = '0;
  logic [31:0] BussB = '0;
  logic [1:0]  ALUControl = '0;
  logic [31:0] Output;
  logic        CarryOut, overflow, negative, zero;

  int total = 0;
  int bad   = 0;

  alu32_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BussA      (BussA),
    .BussB      (BussB),
    .ALUControl (ALUControl),
    .Output     (Output),
    .CarryOut   (CarryOut),
    .overflow   (overflow),
    .negative   (negative),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic c, v, n, z;
  } ref_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: 33-bit arithmetic, sign-rule overflow, signed compare.
  function automatic ref_t model(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
    ref_t r;
    logic [32:0] wide;
    logic [31:0] d;
    logic        is_add;
    is_add = (ctl == 2'b00);
    if (is_add) begin
      wide = {1'b0, a} + {1'b0, b};
      d    = wide[31:0];
      r.c  = wide[32];
      r.v  = (a[31] == b[31]) && (d[31] != a[31]);
    end else begin
      d   = a - b;
      r.c = (a >= b);
      r.v = (a[31] != b[31]) && (d[31] != a[31]);
    end
    case (ctl)
      2'b00, 2'b10: r.res = d;
      2'b01:        r.res = a ^ b;
      default:      r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    r.n = r.res[31];
    r.z = (r.res == 32'd0);
    return r;
  endfunction

  task automatic chk_all(input string tag, input ref_t e);
    chk({tag, ".out"}, Output, e.res);
    chk({tag, ".c"}, {31'd0, CarryOut}, {31'd0, e.c});
    chk({tag, ".v"}, {31'd0, overflow}, {31'd0, e.v});
    chk({tag, ".n"}, {31'd0, negative}, {31'd0, e.n});
    chk({tag, ".z"}, {31'd0, zero}, {31'd0, e.z});
  endtask

  task automatic chk_rst(input string tag);
    ref_t e;
    e.res = '0; e.c = 0; e.v = 0; e.n = 0; e.z = 1;
    chk_all(tag, e);
  endtask

  // Drive away from the edge, clock once, then sample 1ns after the edge.
  task automatic op(input string tag, input logic [1:0] ctl, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp_out);
    ref_t e;
    @(negedge clk);
    ALUControl = ctl; BussA = a; BussB = b;
    e = model(ctl, a, b);
    @(posedge clk); #1;
    chk_all(tag, e);
    chk({tag, ".dir"}, Output, exp_out);
  endtask

  initial begin
    ref_t e;
    logic [31:0] held;
    // reset held with random inputs across edges
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      BussA = $urandom; BussB = $urandom; ALUControl = 2'($urandom);
    end
    @(posedge clk); #1;
    chk_rst("rst");
    @(negedge clk); rst_n = 1'b1;

    op("add0", 2'b00, 32'h0DEF, 32'h0ABC, 32'h000018AB);
    op("addov", 2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000);
    chk("addov.vflag", {31'd0, overflow}, 32'd1);
    op("addz", 2'b00, 32'h0, 32'h0, 32'h0);
    op("sub0", 2'b10, 32'h0DEF, 32'h0ABC, 32'h00000333);
    op("sub1", 2'b10, 32'h1234, 32'h0105, 32'h0000112F);
    op("subov", 2'b10, 32'h80000000, 32'h1, 32'h7FFFFFFF);
    op("subeq", 2'b10, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0);
    op("sub_zero_b", 2'b10, 32'hA5A5_0001, 32'h0, 32'hA5A5_0001);
    chk("sub_zero_b.cflag", {31'd0, CarryOut}, 32'd1);
    op("xor0", 2'b01, 32'h0, 32'h1, 32'h1);
    op("xor1", 2'b01, 32'h0DEF, 32'h0ABC, 32'h00000753);
    op("xor2", 2'b01, 32'h1234, 32'h0105, 32'h00001331);
    op("slt0", 2'b11, 32'h0, 32'h1, 32'h1);
    op("slt1", 2'b11, 32'h1, 32'h0, 32'h0);
    op("slt2", 2'b11, 32'h0, 32'h0, 32'h0);
    op("slt3", 2'b11, 32'h80000000, 32'h1, 32'h1);
    op("slt4", 2'b11, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0);

    // back-to-back random ops, one per cycle
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  c;
      logic [31:0] a, b;
      c = 2'($urandom);
      a = $urandom; b = (i % 5 == 0) ? a : $urandom;
      if (i % 7 == 0) a = {a[31], 31'd0};
      e = model(c, a, b);
      op("rnd", c, a, b, e.res);
    end

    // inputs wiggling between edges must not reach the outputs
    op("hold", 2'b00, 32'h1111_2222, 32'h3333_4444, 32'h4444_6666);
    held = Output;
    for (int i = 0; i < 4; i++) begin
      #1; BussA = $urandom; BussB = $urandom; ALUControl = 2'($urandom);
    end
    chk("hold.stable", Output, held);

    // async reset between edges, then recovery
    op("prerst", 2'b10, 32'h5, 32'h9, 32'hFFFFFFFC);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_rst("arst");
    @(posedge clk); #1;
    chk_rst("arst.hold");
    @(negedge clk); rst_n = 1'b1;
    op("post", 2'b01, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end
endmodule
